moore_detect_sched: RTL

//   Time-multiplexes one 4-state Moore detector across N serial bit channels.
//   A round-robin scheduler grants one channel per cycle and applies its bit to that channel's saved state.
//   It writes the new state back and emits the Moore output tagged with the channel number.

---
 rtl/moore_sched_pkg.sv | 11 +
 rtl/moore_detect_sched_rr_arbiter.sv | 27 ++
 rtl/moore_detect_sched.sv | 91 +++++++++
 3 files changed

// File: rtl/moore_sched_pkg.sv
// moore_sched_pkg: shared detector state encoding, transition/output helpers and counter width
package moore_sched_pkg;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} state_t;
  function automatic state_t next_state(state_t s, logic x);
    return (s == S1 || s == S3) ? (x ? S2 : S3) : (x ? S0 : S1);
  endfunction
  function automatic logic moore_y(state_t s);
    return (s == S0 || s == S2);
  endfunction
endpackage

// File: rtl/moore_detect_sched_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting the search at ptr, plus encoded index
module rr_arbiter #(
  parameter int N = 4,
  localparam int CW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] idx,
  output logic          any
);
  logic [CW-1:0] w_c;
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    w_c = '0;
    for (int k = 0; k < N; k++) begin
      w_c = CW'((int'(ptr) + k) % N);
      if (!any && req[w_c]) begin
        grant[w_c] = 1'b1;
        idx = w_c;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/moore_detect_sched.sv
// moore_detect_sched: one Moore detector time-shared across N serial channels via round-robin.
// Define MOORE_SCHED_CNT_EN to add per-channel saturating accept counters (cnt_sel/cnt_value).
import moore_sched_pkg::*;
module moore_detect_sched #(
  parameter int N = 4,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  ch_valid,
  input  logic [N-1:0]  ch_bit,
  output logic [N-1:0]  ch_ready,
  input  logic [N-1:0]  ch_clr,
  output logic [N-1:0]  ch_y,
`ifdef MOORE_SCHED_CNT_EN
  input  logic [CW-1:0]    cnt_sel,
  output logic [CNT_W-1:0] cnt_value,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ch,
  output logic          out_y
);
  state_t        r_state [N];
  logic [CW-1:0] r_ptr;
  logic          r_out_valid;
  logic [CW-1:0] r_out_ch;
  logic          r_out_y;
  logic          w_stall;
  logic [N-1:0]  w_req;
  logic [N-1:0]  w_grant;
  logic [CW-1:0] w_idx;
  logic          w_acc;
  state_t        w_next;
  assign w_stall = r_out_valid & ~out_ready;
  // cleared channels are masked so their bit stays pending for a later cycle
  assign w_req = ch_valid & ~ch_clr & {N{~w_stall}};
  rr_arbiter #(.N(N)) u_arb (
    .req(w_req),
    .ptr(r_ptr),
    .grant(w_grant),
    .idx(w_idx),
    .any(w_acc)
  );
  assign ch_ready = w_grant;
  always_comb w_next = next_state(r_state[w_idx], ch_bit[w_idx]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_state[i] <= S0;
    end else begin
      for (int i = 0; i < N; i++)
        if (ch_clr[i]) r_state[i] <= S0;
        else if (w_acc && w_idx == CW'(i)) r_state[i] <= w_next;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_out_valid <= 1'b0;
      r_out_ch <= '0;
      r_out_y <= 1'b1;
    end else if (w_acc) begin
      r_ptr <= (w_idx == CW'(N - 1)) ? '0 : w_idx + 1'b1;
      r_out_valid <= 1'b1;
      r_out_ch <= w_idx;
      r_out_y <= moore_y(w_next);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
  always_comb begin
    ch_y = '0;
    for (int i = 0; i < N; i++) ch_y[i] = moore_y(r_state[i]);
  end
  assign out_valid = r_out_valid;
  assign out_ch = r_out_ch;
  assign out_y = r_out_y;
`ifdef MOORE_SCHED_CNT_EN
  logic [CNT_W-1:0] r_cnt [N];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (ch_clr[i]) r_cnt[i] <= '0;
        else if (w_acc && w_idx == CW'(i) && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end
  assign cnt_value = r_cnt[cnt_sel];
`endif
endmodule
